// File: rtl/cache_controller_if.sv
// Signal bundle between the cache sequencer and its CPU, tag/data array and memory neighbours.
// The controller side uses the slave modport; the environment side uses master.
interface cache_controller_if #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned INDEX_W  = 3
);
    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W = 16 << OFFSET_W;

    logic                cpu_req;
    logic                cpu_we;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [15:0]         cpu_wdata;
    logic [15:0]         cpu_rdata;
    logic                cpu_ready;
    logic                stall;

    logic [INDEX_W-1:0]  arr_index;
    logic [TAG_W-1:0]    arr_rd_tag;
    logic                arr_rd_valid;
    logic                arr_rd_dirty;
    logic [LINE_W-1:0]   arr_rd_line;
    logic                arr_we;
    logic [TAG_W-1:0]    arr_wr_tag;
    logic                arr_wr_valid;
    logic                arr_wr_dirty;
    logic [LINE_W-1:0]   arr_wr_line;

    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [LINE_W-1:0]   mem_wdata;
    logic [LINE_W-1:0]   mem_rdata;
    logic                mem_rdy;

    logic [15:0]         hit_cnt;
    logic [15:0]         miss_cnt;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, stall,
        input  arr_index, arr_we, arr_wr_tag, arr_wr_valid, arr_wr_dirty, arr_wr_line,
        output arr_rd_tag, arr_rd_valid, arr_rd_dirty, arr_rd_line,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_rdy,
        input  hit_cnt, miss_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, stall,
        output arr_index, arr_we, arr_wr_tag, arr_wr_valid, arr_wr_dirty, arr_wr_line,
        input  arr_rd_tag, arr_rd_valid, arr_rd_dirty, arr_rd_line,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_rdy,
        output hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_controller.sv
// Sequencer for a direct-mapped write-back cache: compare, write back dirty victim, allocate,
// then re-compare. Keeps saturating hit/miss counters.
module cache_controller #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned OFFSET_W = 2,
    parameter int unsigned INDEX_W  = 3
) (
    input logic               clk,
    input logic               rst_n,
    cache_controller_if.slave bus
);
    localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINE_W = 16 << OFFSET_W;

    typedef enum logic [2:0] {
        StIdle      = 3'b000,
        StCompare   = 3'b001,
        StWriteBack = 3'b010,
        StAllocate  = 3'b100
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [15:0]         wdata_q, wdata_d;
    logic                filled_q, filled_d;
    logic [15:0]         hit_cnt_q, hit_cnt_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                hit;
    logic [15:0]         rd_word;
    logic [LINE_W-1:0]   merged_line;

    assign tag     = addr_q[ADDR_W-1 -: TAG_W];
    assign index   = addr_q[OFFSET_W +: INDEX_W];
    assign offset  = addr_q[OFFSET_W-1:0];
    assign hit     = bus.arr_rd_valid & (bus.arr_rd_tag == tag);
    assign rd_word = bus.arr_rd_line[{offset, 4'b0000} +: 16];

    always_comb begin
        merged_line = bus.arr_rd_line;
        merged_line[{offset, 4'b0000} +: 16] = wdata_q;
    end

    assign bus.arr_index = index;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
    assign bus.stall     = bus.cpu_req & ~bus.cpu_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            filled_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            filled_q   <= filled_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        we_d             = we_q;
        wdata_d          = wdata_q;
        filled_d         = filled_q;
        hit_cnt_d        = hit_cnt_q;
        miss_cnt_d       = miss_cnt_q;
        bus.cpu_rdata    = '0;
        bus.cpu_ready    = 1'b0;
        bus.arr_we       = 1'b0;
        bus.arr_wr_tag   = '0;
        bus.arr_wr_valid = 1'b0;
        bus.arr_wr_dirty = 1'b0;
        bus.arr_wr_line  = '0;
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;

        case (state_q)
            StIdle: begin
                if (bus.cpu_req) begin
                    addr_d   = bus.cpu_addr;
                    we_d     = bus.cpu_we;
                    wdata_d  = bus.cpu_wdata;
                    filled_d = 1'b0;
                    state_d  = StCompare;
                end
            end
            StCompare: begin
                if (hit) begin
                    bus.cpu_ready = 1'b1;
                    if (we_q) begin
                        bus.arr_we       = 1'b1;
                        bus.arr_wr_tag   = bus.arr_rd_tag;
                        bus.arr_wr_valid = 1'b1;
                        bus.arr_wr_dirty = 1'b1;
                        bus.arr_wr_line  = merged_line;
                    end else begin
                        bus.cpu_rdata = rd_word;
                    end
                    // The re-compare after a fill was already counted as a miss.
                    if (!filled_q && hit_cnt_q != 16'hFFFF) begin
                        hit_cnt_d = hit_cnt_q + 16'd1;
                    end
                    state_d = StIdle;
                end else begin
                    if (miss_cnt_q != 16'hFFFF) begin
                        miss_cnt_d = miss_cnt_q + 16'd1;
                    end
                    state_d = (bus.arr_rd_valid && bus.arr_rd_dirty) ? StWriteBack : StAllocate;
                end
            end
            StWriteBack: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {bus.arr_rd_tag, index, {OFFSET_W{1'b0}}};
                bus.mem_wdata = bus.arr_rd_line;
                if (bus.mem_rdy) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {tag, index, {OFFSET_W{1'b0}}};
                if (bus.mem_rdy) begin
                    bus.arr_we       = 1'b1;
                    bus.arr_wr_tag   = tag;
                    bus.arr_wr_valid = 1'b1;
                    bus.arr_wr_dirty = 1'b0;
                    bus.arr_wr_line  = bus.mem_rdata;
                    filled_d         = 1'b1;
                    state_d          = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: array and memory models around the DUT, a word-level reference
// model of the cache, directed scenarios and a randomized access stream.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if bus ();

    cache_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [63:0] data;
    } txn_t;

    typedef struct {
        logic [10:0] tag;
        logic        valid;
        logic        dirty;
        logic [63:0] line;
    } aw_t;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Initial main-memory contents; line 0x0040 holds words 1..4.
    function automatic logic [15:0] init_word(input logic [15:0] a);
        logic [15:0] v;
        if (a[15:2] == 14'h0010) return {14'b0, a[1:0]} + 16'd1;
        v = a ^ 16'hA5C3;
        return {v[7:0], v[15:8]} + a;
    endfunction

    // Environment: tag/data array (left untouched by reset)
    logic [10:0] a_tag   [8] = '{default: 11'h0};
    logic        a_valid [8] = '{default: 1'b0};
    logic        a_dirty [8] = '{default: 1'b0};
    logic [63:0] a_line  [8] = '{default: 64'h0};

    assign bus.arr_rd_tag   = a_tag[bus.arr_index];
    assign bus.arr_rd_valid = a_valid[bus.arr_index];
    assign bus.arr_rd_dirty = a_dirty[bus.arr_index];
    assign bus.arr_rd_line  = a_line[bus.arr_index];

    always @(posedge clk) begin
        if (bus.arr_we) begin
            a_tag[bus.arr_index]   <= bus.arr_wr_tag;
            a_valid[bus.arr_index] <= bus.arr_wr_valid;
            a_dirty[bus.arr_index] <= bus.arr_wr_dirty;
            a_line[bus.arr_index]  <= bus.arr_wr_line;
        end
    end

    // Environment: main memory with latency mem_lat cycles per transaction
    logic [15:0] memw [int];
    int          mem_lat = 4;
    int          rsp_cnt = 0;
    logic        rsp_rdy = 1'b0;
    logic        extra_rdy = 1'b0;
    logic [63:0] rsp_data = 64'h0;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return memw.exists(int'(a)) ? memw[int'(a)] : init_word(a);
    endfunction

    assign bus.mem_rdy   = rsp_rdy | extra_rdy;
    assign bus.mem_rdata = rsp_data;

    always @(posedge clk) begin
        #1;
        rsp_rdy = 1'b0;
        if (!rst_n || !bus.mem_req) begin
            rsp_cnt = 0;
        end else begin
            rsp_cnt++;
            if (rsp_cnt >= mem_lat) begin
                rsp_cnt = 0;
                rsp_rdy = 1'b1;
                if (bus.mem_we) begin
                    for (int w = 0; w < 4; w++)
                        memw[int'(bus.mem_addr) + w] = bus.mem_wdata[16*w +: 16];
                end else begin
                    for (int w = 0; w < 4; w++)
                        rsp_data[16*w +: 16] = mem_rd(bus.mem_addr + 16'(w));
                end
            end
        end
    end

    // Monitor: records transactions and checks cycle-level output rules
    txn_t obs_q[$];
    aw_t  aw_q[$];
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        if (bus.arr_we)
            aw_q.push_back('{bus.arr_wr_tag, bus.arr_wr_valid, bus.arr_wr_dirty, bus.arr_wr_line});
        if (bus.mem_req && bus.mem_rdy)
            obs_q.push_back('{bus.mem_we, bus.mem_addr, bus.mem_wdata});
        if (mon_en && rst_n) begin
            check("stall", 64'(bus.stall), 64'(bus.cpu_req & ~bus.cpu_ready));
            if (!bus.cpu_ready) check("rdata_idle", 64'(bus.cpu_rdata), 64'(0));
            if (!bus.mem_req) begin
                check("mem_addr_idle", 64'(bus.mem_addr), 64'(0));
                check("mem_we_idle", 64'(bus.mem_we), 64'(0));
            end else begin
                check("mem_addr_align", 64'(bus.mem_addr[1:0]), 64'(0));
            end
        end
    end

    // Reference model: architectural word values plus which line sits at each index
    logic [15:0] ref_word [int];
    logic        m_valid [8] = '{default: 1'b0};
    logic [10:0] m_tag   [8] = '{default: 11'h0};
    logic        m_dirty [8] = '{default: 1'b0};
    logic [15:0] m_hits = 16'h0;
    logic [15:0] m_miss = 16'h0;
    int          exp_lat;
    logic [15:0] exp_rdata;
    txn_t        exp_q[$];

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_word.exists(int'(a)) ? ref_word[int'(a)] : init_word(a);
    endfunction

    function automatic logic [63:0] ref_line(input logic [15:0] base);
        return {ref_rd(base + 16'd3), ref_rd(base + 16'd2), ref_rd(base + 16'd1), ref_rd(base)};
    endfunction

    task automatic model_access(input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        int          idx = int'(addr[4:2]);
        logic [15:0] victim;
        exp_q.delete();
        if (m_valid[idx] && m_tag[idx] == addr[15:5]) begin
            exp_lat = 1;
            if (m_hits != 16'hFFFF) m_hits++;
        end else begin
            if (m_miss != 16'hFFFF) m_miss++;
            exp_lat = 2 + mem_lat;
            if (m_valid[idx] && m_dirty[idx]) begin
                victim = {m_tag[idx], addr[4:2], 2'b00};
                exp_q.push_back('{1'b1, victim, ref_line(victim)});
                exp_lat += mem_lat;
            end
            exp_q.push_back('{1'b0, {addr[15:2], 2'b00}, 64'h0});
            m_valid[idx] = 1'b1;
            m_tag[idx]   = addr[15:5];
            m_dirty[idx] = 1'b0;
        end
        exp_rdata = ref_rd(addr);
        if (we) begin
            ref_word[int'(addr)] = wdata;
            m_dirty[idx] = 1'b1;
        end
    endtask

    int          lat_seen;
    logic [15:0] rdata_seen;

    // One CPU access, checked against the model; returns at the IDLE cycle after completion.
    task automatic do_access(input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        int n;
        model_access(we, addr, wdata);
        @(negedge clk);
        obs_q.delete();
        aw_q.delete();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(posedge clk);
        lat_seen = 0;
        do begin
            @(negedge clk);
            lat_seen++;
        end while (!bus.cpu_ready && lat_seen < 200);
        rdata_seen  = bus.cpu_rdata;
        bus.cpu_req = 1'b0;
        #1;
        check("latency", 64'(lat_seen), 64'(exp_lat));
        if (!we) check("rdata", 64'(rdata_seen), 64'(exp_rdata));
        check("mem_txn_count", 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("mem_txn_we", 64'(obs_q[i].we), 64'(exp_q[i].we));
            check("mem_txn_addr", 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            if (exp_q[i].we) check("mem_txn_wdata", obs_q[i].data, exp_q[i].data);
        end
        @(negedge clk);
        check("hit_cnt", 64'(bus.hit_cnt), 64'(m_hits));
        check("miss_cnt", 64'(bus.miss_cnt), 64'(m_miss));
    endtask

    logic [15:0] last_addr = 16'h0040;

    initial begin
        int cyc;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_cpu_ready", 64'(bus.cpu_ready), 64'(0));
        check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'(0));
        check("rst_arr_we", 64'(bus.arr_we), 64'(0));
        check("rst_arr_index", 64'(bus.arr_index), 64'(0));
        check("rst_arr_wr_line", bus.arr_wr_line, 64'(0));
        check("rst_mem_req", 64'(bus.mem_req), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_mem_wdata", bus.mem_wdata, 64'(0));
        check("rst_hit_cnt", 64'(bus.hit_cnt), 64'(0));
        check("rst_miss_cnt", 64'(bus.miss_cnt), 64'(0));
        mon_en = 1'b1;

        // Cold read miss on line 0x0040
        mem_lat = 4;
        do_access(1'b0, 16'h0040, 16'h0);
        check("t1_latency", 64'(lat_seen), 64'(6));
        check("t1_rdata", 64'(rdata_seen), 64'(16'h0001));
        check("t1_txns", 64'(obs_q.size()), 64'(1));
        if (obs_q.size() > 0) check("t1_mem_addr", 64'(obs_q[0].addr), 64'(16'h0040));
        check("t1_arr_writes", 64'(aw_q.size()), 64'(1));
        if (aw_q.size() > 0) begin
            check("t1_wr_tag", 64'(aw_q[0].tag), 64'(11'h002));
            check("t1_wr_valid", 64'(aw_q[0].valid), 64'(1));
            check("t1_wr_dirty", 64'(aw_q[0].dirty), 64'(0));
            check("t1_wr_line", aw_q[0].line, 64'h0004_0003_0002_0001);
        end
        check("t1_miss_cnt", 64'(bus.miss_cnt), 64'(1));
        check("t1_hit_cnt", 64'(bus.hit_cnt), 64'(0));

        // Read hit
        do_access(1'b0, 16'h0041, 16'h0);
        check("t2_latency", 64'(lat_seen), 64'(1));
        check("t2_rdata", 64'(rdata_seen), 64'(16'h0002));
        check("t2_txns", 64'(obs_q.size()), 64'(0));
        check("t2_hit_cnt", 64'(bus.hit_cnt), 64'(1));

        // Write hit
        do_access(1'b1, 16'h0042, 16'hBEEF);
        check("t3_latency", 64'(lat_seen), 64'(1));
        check("t3_txns", 64'(obs_q.size()), 64'(0));
        check("t3_arr_writes", 64'(aw_q.size()), 64'(1));
        if (aw_q.size() > 0) begin
            check("t3_wr_line", aw_q[0].line, 64'h0004_BEEF_0002_0001);
            check("t3_wr_dirty", 64'(aw_q[0].dirty), 64'(1));
            check("t3_wr_tag", 64'(aw_q[0].tag), 64'(11'h002));
        end

        // Dirty miss: write-back of 0x0040 then allocate 0x0440
        do_access(1'b0, 16'h0440, 16'h0);
        check("t4_latency", 64'(lat_seen), 64'(10));
        check("t4_txns", 64'(obs_q.size()), 64'(2));
        if (obs_q.size() == 2) begin
            check("t4_wb_we", 64'(obs_q[0].we), 64'(1));
            check("t4_wb_addr", 64'(obs_q[0].addr), 64'(16'h0040));
            check("t4_wb_data", obs_q[0].data, 64'h0004_BEEF_0002_0001);
            check("t4_alloc_we", 64'(obs_q[1].we), 64'(0));
            check("t4_alloc_addr", 64'(obs_q[1].addr), 64'(16'h0440));
        end
        check("t4_miss_cnt", 64'(bus.miss_cnt), 64'(2));

        // Reset during ALLOCATE of 0x0084, then a stray mem_rdy
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0084;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_in_alloc", 64'(bus.mem_req), 64'(1));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_hits = 16'h0;
        m_miss = 16'h0;
        check("t5_mem_req", 64'(bus.mem_req), 64'(0));
        check("t5_cpu_ready", 64'(bus.cpu_ready), 64'(0));
        check("t5_hit_cnt", 64'(bus.hit_cnt), 64'(0));
        check("t5_miss_cnt", 64'(bus.miss_cnt), 64'(0));
        aw_q.delete();
        extra_rdy = 1'b1;
        #1;
        check("t5_late_arr_we", 64'(bus.arr_we), 64'(0));
        @(negedge clk);
        extra_rdy = 1'b0;
        check("t5_late_writes", 64'(aw_q.size()), 64'(0));
        check("t5_still_idle", 64'(bus.mem_req), 64'(0));

        // Randomized accesses over a few aliasing tags
        for (int i = 0; i < 150; i++) begin
            int          sel = $urandom_range(0, 4);
            logic [10:0] tg  = (sel == 4) ? 11'h022 : 11'(sel);
            logic [15:0] a   = {tg, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            mem_lat = $urandom_range(1, 5);
            do_access(1'($urandom_range(0, 1)), a, 16'($urandom));
            last_addr = a;
        end

        // Saturated hit counter, with cpu_req held across completion
        @(negedge clk);
        force dut.hit_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        m_hits = 16'hFFFF;
        check("t6_forced", 64'(bus.hit_cnt), 64'(16'hFFFF));
        model_access(1'b0, last_addr, 16'h0);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = last_addr;
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.cpu_ready && cyc < 50);
        check("t6_first_latency", 64'(cyc), 64'(1));
        check("t6_first_rdata", 64'(bus.cpu_rdata), 64'(exp_rdata));
        model_access(1'b0, last_addr, 16'h0);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.cpu_ready && cyc < 50);
        bus.cpu_req = 1'b0;
        check("t6_second_latency", 64'(cyc), 64'(2));
        check("t6_second_rdata", 64'(bus.cpu_rdata), 64'(exp_rdata));
        @(negedge clk);
        check("t6_hit_sat", 64'(bus.hit_cnt), 64'(16'hFFFF));
        check("t6_hit_model", 64'(bus.hit_cnt), 64'(m_hits));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
